// File: rtl/bleuart_tx_arbiter_if.sv
// Requester byte streams plus the TX FIFO write port, as seen by the arbiter.
// The slave modport is the arbiter; the master modport drives requesters and the FIFO status.
interface bleuart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_rdy;
  logic                 fifo_write;
  logic [7:0]           fifo_data;
  logic                 fifo_full;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_rdy, fifo_write, fifo_data
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_rdy, fifo_write, fifo_data
  );
endinterface

// File: rtl/bleuart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the BLE UART TX FIFO write port.
// Optional BLEUART_ARB_SRC_TAG_EN: emits a source tag byte (8'hA0 | grant) before each packet.
module bleuart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  bleuart_tx_arbiter_if.slave  bus,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 pkt_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TAG  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [ID_W-1:0]      grant_r;
  logic [ID_W-1:0]      rr_ptr_r;
  logic                 pkt_done_r;
  logic [ID_W-1:0]      pick_id_s;
  logic                 pick_valid_s;
  int                   best_dist_s;
  int                   dist_s;
  logic [NUM_REQ-1:0]   hit_s;
  logic                 sel_valid_s;
  logic                 sel_last_s;
  logic [7:0]           sel_data_s;
  logic [NUM_REQ-1:0]   rdy_s;
  logic                 write_s;
  logic [7:0]           data_s;
  logic                 last_wr_s;

  // Round-robin pick: the valid requester at the smallest cyclic distance from rr_ptr wins.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_id_s    = '0;
    best_dist_s  = NUM_REQ;
    dist_s       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_s = (i >= int'(rr_ptr_r)) ? (i - int'(rr_ptr_r)) : (i - int'(rr_ptr_r) + NUM_REQ);
      if (bus.req_valid[i] && (dist_s < best_dist_s)) begin
        best_dist_s  = dist_s;
        pick_id_s    = ID_W'(i);
        pick_valid_s = 1'b1;
      end else begin
        best_dist_s  = best_dist_s;
      end
    end
  end

  // Select the granted requester's valid/data/last without variable indexing.
  always_comb begin
    hit_s       = '0;
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      hit_s[i]    = (grant_r == ID_W'(i));
      sel_valid_s = sel_valid_s | (bus.req_valid[i] & hit_s[i]);
      sel_last_s  = sel_last_s  | (bus.req_last[i]  & hit_s[i]);
      sel_data_s  = sel_data_s  | (bus.req_data[8*i +: 8] & {8{hit_s[i]}});
    end
  end

  // Next state and the FIFO-facing handshake.
  always_comb begin
    state_s   = state_r;
    rdy_s     = '0;
    write_s   = 1'b0;
    data_s    = 8'h00;
    last_wr_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
`ifdef BLEUART_ARB_SRC_TAG_EN
          state_s = TAG;
`else
          state_s = XFER;
`endif
        end else begin
          state_s = IDLE;
        end
      end
`ifdef BLEUART_ARB_SRC_TAG_EN
      TAG: begin
        write_s = ~bus.fifo_full;
        data_s  = bus.fifo_full ? 8'h00 : (8'hA0 | 8'(grant_r));
        if (bus.fifo_full) begin
          state_s = TAG;
        end else begin
          state_s = XFER;
        end
      end
`endif
      XFER: begin
        rdy_s     = hit_s & {NUM_REQ{~bus.fifo_full}};
        write_s   = sel_valid_s & ~bus.fifo_full;
        data_s    = write_s ? sel_data_s : 8'h00;
        last_wr_s = write_s & sel_last_s;
        if (last_wr_s) begin
          state_s = IDLE;
        end else begin
          state_s = XFER;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, grant latch and rotation pointer; the pointer moves only when a packet completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      grant_r    <= '0;
      rr_ptr_r   <= '0;
      pkt_done_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      pkt_done_r <= last_wr_s;
      if ((state_r == IDLE) && pick_valid_s) begin
        grant_r <= pick_id_s;
      end
      if (last_wr_s) begin
        rr_ptr_r <= (grant_r == ID_W'(NUM_REQ - 1)) ? '0 : (grant_r + ID_W'(1));
      end
    end
  end

  assign bus.req_rdy    = rdy_s;
  assign bus.fifo_write = write_s;
  assign bus.fifo_data  = data_s;
  assign grant_id       = grant_r;
  assign busy           = (state_r != IDLE);
  assign pkt_done       = pkt_done_r;

endmodule

// File: tb/tb_bleuart_tx_arbiter.sv
// Bench for bleuart_tx_arbiter: requester byte queues, a packet-level round-robin model,
// and directed plus randomized scenarios. Honors BLEUART_ARB_SRC_TAG_EN.
module tb_bleuart_tx_arbiter;
  localparam int N   = 3;
  localparam int IDW = 3;
`ifdef BLEUART_ARB_SRC_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [IDW-1:0] grant_id;
  logic busy;
  logic pkt_done;

  always #5 clk = ~clk;

  bleuart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  bleuart_tx_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .grant_id (grant_id),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt, both_rdy_cnt, stall_viol, model_ptr;
  bit prev_busy, full, rand_full;
  bit hold [N];
  logic [8:0] rq   [N][$];
  logic [8:0] snap [N][$];
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  int cap_cyc[$];
  int grant_q[$];
  int exp_g[$];

  task automatic drive_inputs();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && !hold[i]) begin
        e = rq[i][0];
        bus.req_valid[i]       = 1'b1;
        bus.req_data[8*i +: 8] = e[7:0];
        bus.req_last[i]        = e[8];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i]        = 1'b0;
      end
    end
    bus.fifo_full = full;
  endtask

  // One clock: observe at the falling edge, then advance the requester queues after the rising edge.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = bus.req_valid & bus.req_rdy;
    if (bus.fifo_write) begin
      cap_q.push_back(bus.fifo_data);
      cap_cyc.push_back(cyc);
    end
    if ($countones(bus.req_rdy) > 1) both_rdy_cnt++;
    if (full && (bus.fifo_write || (bus.req_rdy != {N{1'b0}}))) stall_viol++;
    if (pkt_done) done_cnt++;
    if (busy && !prev_busy) grant_q.push_back(int'(grant_id));
    prev_busy = busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(rq[i].pop_front());
    cyc++;
    if (rand_full) full = ($urandom_range(0, 3) == 0);
    drive_inputs();
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic clear_obs();
    cap_q.delete(); cap_cyc.delete(); grant_q.delete();
    done_cnt = 0; both_rdy_cnt = 0; stall_viol = 0;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  // Packet-level model: whole packets, granted in round-robin order from the last winner + 1.
  task automatic build_expected();
    int found;
    bit more;
    logic [8:0] e;
    for (int i = 0; i < N; i++) snap[i] = rq[i];
    exp_q.delete(); exp_g.delete();
    more = 1'b1;
    while (more) begin
      found = -1;
      for (int k = 0; k < N; k++)
        if (found < 0 && snap[(model_ptr + k) % N].size() > 0) found = (model_ptr + k) % N;
      if (found < 0) begin
        more = 1'b0;
      end else begin
        exp_g.push_back(found);
        if (TAG_EN) exp_q.push_back(8'hA0 | 8'(found));
        do begin
          e = snap[found].pop_front();
          exp_q.push_back(e[7:0]);
        end while (!e[8] && snap[found].size() > 0);
        model_ptr = (found + 1) % N;
      end
    end
  endtask

  task automatic run_until_idle(input int max, output bit to);
    int n = 0;
    while ((pending() || busy) && n < max) begin
      step();
      n++;
    end
    to = (n >= max);
    step();
    step();
  endtask

  task automatic test_reset();
    full = 1'b0; rand_full = 1'b0;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    drive_inputs();
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
    checks++; if (bus.fifo_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", bus.fifo_write); end
    checks++; if (bus.req_rdy !== {N{1'b0}}) begin errors++; $display("FAIL reset_rdy: got %b expected 0", bus.req_rdy); end
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", pkt_done); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    prev_busy = 1'b0; model_ptr = 0;
  endtask

  task automatic test_single_packet();
    bit to;
    int start;
    push_byte(0, 8'h11, 1'b0); push_byte(0, 8'h22, 1'b0); push_byte(0, 8'h33, 1'b1);
    clear_obs(); build_expected();
    start = cyc;
    drive_inputs();
    run_until_idle(50, to);
    checks++; if (to) begin errors++; $display("FAIL single_timeout: still busy after 50 cycles"); end
    checks++;
    if (cap_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_len: got %0d bytes expected %0d", cap_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (cap_q[k] !== exp_q[k]) begin errors++; $display("FAIL single_byte%0d: got %h expected %h", k, cap_q[k], exp_q[k]); end
      end
      checks++;
      if (cap_cyc[TAG_EN] != start + 1 + TAG_EN) begin
        errors++; $display("FAIL single_latency: first data at cycle %0d expected %0d", cap_cyc[TAG_EN], start + 1 + TAG_EN);
      end
      checks++;
      if (cap_cyc[TAG_EN + 2] != cap_cyc[TAG_EN] + 2) begin
        errors++; $display("FAIL single_consecutive: last at %0d expected %0d", cap_cyc[TAG_EN + 2], cap_cyc[TAG_EN] + 2);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done: got %0d pulses expected 1", done_cnt); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL single_grant: got %0d expected 0", grant_id); end
  endtask

  task automatic test_round_robin();
    bit to;
    push_byte(0, 8'h01, 1'b0); push_byte(0, 8'h02, 1'b1); push_byte(0, 8'h03, 1'b0); push_byte(0, 8'h04, 1'b1);
    push_byte(1, 8'h81, 1'b0); push_byte(1, 8'h82, 1'b1); push_byte(1, 8'h83, 1'b0); push_byte(1, 8'h84, 1'b1);
    clear_obs(); build_expected();
    drive_inputs();
    run_until_idle(80, to);
    checks++; if (to) begin errors++; $display("FAIL rr_timeout: still busy after 80 cycles"); end
    checks++;
    if (cap_q != exp_q) begin errors++; $display("FAIL rr_stream: got %p expected %p", cap_q, exp_q); end
    checks++;
    if (grant_q != exp_g) begin errors++; $display("FAIL rr_grants: got %p expected %p", grant_q, exp_g); end
    checks++; if (both_rdy_cnt != 0) begin errors++; $display("FAIL rr_onehot: %0d cycles with multiple req_rdy, expected 0", both_rdy_cnt); end
    checks++; if (done_cnt != 4) begin errors++; $display("FAIL rr_done: got %0d pulses expected 4", done_cnt); end
  endtask

  task automatic test_full_stall();
    bit to;
    int n, base;
    push_byte(1, 8'h11, 1'b0); push_byte(1, 8'h5A, 1'b0); push_byte(1, 8'h33, 1'b1);
    clear_obs(); build_expected();
    drive_inputs();
    n = 0;
    while (cap_q.size() < 1 + TAG_EN && n < 20) begin step(); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL stall_start: first byte not written in 20 cycles"); end
    full = 1'b1; drive_inputs();
    base = cap_q.size();
    repeat (5) step();
    checks++; if (cap_q.size() != base) begin errors++; $display("FAIL stall_nowrite: got %0d writes while full expected 0", cap_q.size() - base); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_rdy: %0d cycles with write/rdy while full expected 0", stall_viol); end
    full = 1'b0; drive_inputs();
    step();
    checks++;
    if (cap_q.size() != base + 1) begin
      errors++; $display("FAIL stall_resume: got %0d writes expected 1", cap_q.size() - base);
    end else if (cap_q[base] !== 8'h5A) begin
      errors++; $display("FAIL stall_resume: got %h expected 5a", cap_q[base]);
    end
    run_until_idle(50, to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout: still busy after 50 cycles"); end
    checks++; if (cap_q != exp_q) begin errors++; $display("FAIL stall_stream: got %p expected %p", cap_q, exp_q); end
  endtask

  task automatic test_valid_gap();
    bit to;
    int n;
    if (model_ptr != 0) begin
      push_byte(N - 1, 8'hEE, 1'b1);
      build_expected(); drive_inputs();
      run_until_idle(30, to);
    end
    clear_obs();
    push_byte(0, 8'h21, 1'b0); push_byte(0, 8'h22, 1'b0); push_byte(0, 8'h23, 1'b1);
    drive_inputs();
    n = 0;
    while (cap_q.size() < 1 + TAG_EN && n < 20) begin step(); n++; end
    hold[0] = 1'b1;
    push_byte(1, 8'h31, 1'b1);
    drive_inputs();
    repeat (3) step();
    checks++; if (cap_q.size() != 1 + TAG_EN) begin errors++; $display("FAIL gap_writes: got %0d bytes expected %0d", cap_q.size(), 1 + TAG_EN); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL gap_grant: got %0d expected 0", grant_id); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy: got %b expected 1", busy); end
    hold[0] = 1'b0; drive_inputs();
    run_until_idle(50, to);
    exp_q.delete();
    if (TAG_EN) exp_q.push_back(8'hA0);
    exp_q.push_back(8'h21); exp_q.push_back(8'h22); exp_q.push_back(8'h23);
    if (TAG_EN) exp_q.push_back(8'hA1);
    exp_q.push_back(8'h31);
    model_ptr = 2;
    checks++; if (to) begin errors++; $display("FAIL gap_timeout: still busy after 50 cycles"); end
    checks++; if (cap_q != exp_q) begin errors++; $display("FAIL gap_stream: got %p expected %p", cap_q, exp_q); end
    checks++; if (grant_q.size() != 2 || grant_q[0] != 0 || grant_q[1] != 1) begin errors++; $display("FAIL gap_order: got %p expected '{0, 1}", grant_q); end
  endtask

  task automatic test_tag();
    bit to;
    logic [7:0] first_exp;
    push_byte(1, 8'h7E, 1'b1);
    clear_obs(); build_expected();
    drive_inputs();
    run_until_idle(30, to);
    first_exp = TAG_EN ? 8'hA1 : 8'h7E;
    checks++;
    if (cap_q.size() != 1 + TAG_EN) begin
      errors++; $display("FAIL tag_len: got %0d bytes expected %0d", cap_q.size(), 1 + TAG_EN);
    end else begin
      checks++; if (cap_q[0] !== first_exp) begin errors++; $display("FAIL tag_first: got %h expected %h", cap_q[0], first_exp); end
      checks++; if (cap_q[TAG_EN] !== 8'h7E) begin errors++; $display("FAIL tag_data: got %h expected 7e", cap_q[TAG_EN]); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    push_byte(1, 8'h01, 1'b0); push_byte(1, 8'h02, 1'b0); push_byte(1, 8'h03, 1'b0); push_byte(1, 8'h04, 1'b1);
    clear_obs(); drive_inputs();
    n = 0;
    while (cap_q.size() < 1 + TAG_EN && n < 20) begin step(); n++; end
    #1 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL rstmid_grant: got %0d expected 0", grant_id); end
    checks++; if (bus.fifo_write !== 1'b0) begin errors++; $display("FAIL rstmid_write: got %b expected 0", bus.fifo_write); end
    @(posedge clk); @(posedge clk);
    for (int i = 0; i < N; i++) rq[i].delete();
    #1 rst = 1'b1;
    prev_busy = 1'b0; model_ptr = 0;
    for (int i = 0; i < N; i++) push_byte(i, 8'(8'h40 + i), 1'b1);
    clear_obs(); build_expected(); drive_inputs();
    run_until_idle(50, to);
    checks++; if (grant_q.size() == 0 || grant_q[0] != 0) begin errors++; $display("FAIL rstmid_first: got %p expected first grant 0", grant_q); end
    checks++; if (cap_q != exp_q) begin errors++; $display("FAIL rstmid_stream: got %p expected %p", cap_q, exp_q); end
  endtask

  task automatic test_random();
    bit to;
    int npk, total, len;
    for (int round = 0; round < 30; round++) begin
      total = 0;
      for (int r = 0; r < N; r++) begin
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push_byte(r, 8'($urandom_range(0, 255)), b == len - 1);
          total++;
        end
      end
      clear_obs(); build_expected();
      rand_full = 1'b1;
      drive_inputs();
      run_until_idle(400, to);
      checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout: still busy after 400 cycles", round); end
      checks++; if (cap_q != exp_q) begin errors++; $display("FAIL rand%0d_stream: got %0d bytes expected %0d", round, cap_q.size(), exp_q.size()); end
      checks++; if (grant_q != exp_g) begin errors++; $display("FAIL rand%0d_grants: got %p expected %p", round, grant_q, exp_g); end
      checks++; if (done_cnt != total) begin errors++; $display("FAIL rand%0d_done: got %0d pulses expected %0d", round, done_cnt, total); end
      checks++; if (stall_viol != 0 || both_rdy_cnt != 0) begin errors++; $display("FAIL rand%0d_hs: stall %0d onehot %0d expected 0", round, stall_viol, both_rdy_cnt); end
    end
    rand_full = 1'b0; full = 1'b0; drive_inputs();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_full_stall();
    test_valid_gap();
    test_tag();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
